// File: rtl/sys_defs_pkg.sv
// Shared processor/memory definitions: bus commands, access sizes and the
// store-writer state encoding.
package sys_defs;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_command_t;

  typedef enum logic [1:0] {
    BYTE   = 2'd0,
    HALF   = 2'd1,
    WORD   = 2'd2,
    DOUBLE = 2'd3
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } sw_state_t;

endpackage

// File: rtl/store_lane_align.sv
// Places right-justified store data into its byte lane of the memory bus and
// flags accesses that cross their natural alignment.
module store_lane_align
  import sys_defs::*;
#(
  parameter int XLEN   = 32,
  parameter int MEM_DW = 64
) (
  input  logic [1:0]        size,
  input  logic [2:0]        lane,
  input  logic [XLEN-1:0]   data,
  output logic              misalign,
  output logic [MEM_DW-1:0] lane_data
);

  logic [MEM_DW-1:0] masked;

  always_comb begin
    masked   = '0;
    misalign = 1'b0;
    case (mem_size_t'(size))
      BYTE: masked = MEM_DW'(data[7:0]);
      HALF: begin
        masked   = MEM_DW'(data[15:0]);
        misalign = lane[0];
      end
      WORD: begin
        masked   = MEM_DW'(data);
        misalign = |lane[1:0];
      end
      default: begin
        masked   = MEM_DW'(data);
        misalign = |lane;
      end
    endcase
    lane_data = masked << {lane, 3'b000};
  end

endmodule

// File: rtl/sq_store_writer.sv
// Retire-write responder: issues the store queue head as a BUS_STORE when the
// memory port is granted, retries on refusal and pulses storecomplete.
//
// state | meaning
// IDLE  | waiting for a retiring store; latches it when st_req is seen
// ISSUE | requesting the port; command driven on granted cycles until accepted
// DONE  | one-cycle storecomplete (with st_misalign for dropped stores)
module sq_store_writer
  import sys_defs::*;
#(
  parameter int XLEN      = 32,
  parameter int MEM_DW    = 64,
  parameter int RETRY_MAX = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              st_req,
  input  logic [XLEN-1:0]   st_addr,
  input  logic [XLEN-1:0]   st_data,
  input  logic [2:0]        st_memsize,
  input  logic              mem_grant,
  input  logic [3:0]        mem2proc_response,
  output logic              storecomplete,
  output logic              mem_req,
  output logic [1:0]        proc2mem_command,
  output logic [XLEN-1:0]   proc2mem_addr,
  output logic [MEM_DW-1:0] proc2mem_data,
  output logic [1:0]        proc2mem_size,
  output logic              st_misalign,
  output logic              st_timeout,
  output logic              busy
);

  localparam int CW = $clog2(RETRY_MAX + 1);
  localparam logic [CW-1:0] RMAX    = CW'(RETRY_MAX);
  localparam logic [CW-1:0] RMAX_M1 = CW'(RETRY_MAX - 1);

  sw_state_t         state;
  logic [XLEN-4:0]   line_q;
  logic [MEM_DW-1:0] data_q;
  logic [1:0]        size_q;
  logic              misalign_q;
  logic [CW-1:0]     retry_cnt;

  logic              misalign_in;
  logic [MEM_DW-1:0] lane_data_in;
  logic              unused_memsize_sign;

  // Unsigned-load bit has no meaning for a store.
  assign unused_memsize_sign = st_memsize[2];

  store_lane_align #(
    .XLEN   (XLEN),
    .MEM_DW (MEM_DW)
  ) u_align (
    .size      (st_memsize[1:0]),
    .lane      (st_addr[2:0]),
    .data      (st_data),
    .misalign  (misalign_in),
    .lane_data (lane_data_in)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      line_q     <= '0;
      data_q     <= '0;
      size_q     <= '0;
      misalign_q <= 1'b0;
      retry_cnt  <= '0;
      st_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (st_req) begin
            line_q     <= st_addr[XLEN-1:3];
            data_q     <= lane_data_in;
            size_q     <= st_memsize[1:0];
            misalign_q <= misalign_in;
            state      <= misalign_in ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          if (mem_grant) begin
            if (mem2proc_response != 4'd0) begin
              state <= DONE;
            end else begin
              if (retry_cnt != RMAX) retry_cnt <= retry_cnt + CW'(1);
              if (retry_cnt >= RMAX_M1) st_timeout <= 1'b1;
            end
          end
        end
        DONE: begin
          retry_cnt  <= '0;
          misalign_q <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy             = (state != IDLE);
  assign mem_req          = (state == ISSUE);
  assign storecomplete    = (state == DONE);
  assign st_misalign      = (state == DONE) && misalign_q;
  // Command follows the grant of the current cycle; payload comes from the latch.
  assign proc2mem_command = (state == ISSUE && mem_grant) ? BUS_STORE : BUS_NONE;
  assign proc2mem_addr    = {line_q, 3'b000};
  assign proc2mem_data    = data_q;
  assign proc2mem_size    = size_q;

endmodule

// File: tb/tb_sq_store_writer.sv
// Directed bench for sq_store_writer with hand-computed expected bus values.
module tb_sq_store_writer;

  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_STORE = 2'd2;

  logic        clock = 1'b0;
  logic        reset;
  logic        st_req;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  st_memsize;
  logic        mem_grant;
  logic [3:0]  mem2proc_response;
  logic        storecomplete;
  logic        mem_req;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [1:0]  proc2mem_size;
  logic        st_misalign;
  logic        st_timeout;
  logic        busy;

  int vec = 0;
  int miscompares = 0;

  sq_store_writer #(.XLEN(32), .MEM_DW(64), .RETRY_MAX(4)) dut (
    .clock             (clock),
    .reset             (reset),
    .st_req            (st_req),
    .st_addr           (st_addr),
    .st_data           (st_data),
    .st_memsize        (st_memsize),
    .mem_grant         (mem_grant),
    .mem2proc_response (mem2proc_response),
    .storecomplete     (storecomplete),
    .mem_req           (mem_req),
    .proc2mem_command  (proc2mem_command),
    .proc2mem_addr     (proc2mem_addr),
    .proc2mem_data     (proc2mem_data),
    .proc2mem_size     (proc2mem_size),
    .st_misalign       (st_misalign),
    .st_timeout        (st_timeout),
    .busy              (busy)
  );

  always #5 clock = ~clock;

  task automatic present(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s);
    st_req = 1'b1; st_addr = a; st_data = d; st_memsize = s;
  endtask

  task automatic test_reset;
    reset = 1'b1; st_req = 1'b0; st_addr = '0; st_data = '0; st_memsize = '0;
    mem_grant = 1'b1; mem2proc_response = 4'd1;
    repeat (2) @(negedge clock);
    vec++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0b want 0", busy); end
    vec++; if (storecomplete !== 1'b0) begin miscompares++; $display("FAIL reset_sc got %0b want 0", storecomplete); end
    vec++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req got %0b want 0", mem_req); end
    vec++; if (proc2mem_command !== CMD_NONE) begin miscompares++; $display("FAIL reset_cmd got %0d want 0", proc2mem_command); end
    vec++; if (proc2mem_data !== 64'h0 || proc2mem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_bus got %h/%h want 0/0", proc2mem_addr, proc2mem_data); end
    vec++; if (st_timeout !== 1'b0 || st_misalign !== 1'b0) begin miscompares++; $display("FAIL reset_err got %0b%0b want 00", st_timeout, st_misalign); end
    reset = 1'b0;
  endtask

  task automatic test_word;
    present(32'h1004, 32'hDEADBEEF, 3'd2);
    @(negedge clock);
    vec++; if (proc2mem_command !== CMD_STORE) begin miscompares++; $display("FAIL word_cmd got %0d want 2", proc2mem_command); end
    vec++; if (proc2mem_addr !== 32'h1000) begin miscompares++; $display("FAIL word_addr got %h want 00001000", proc2mem_addr); end
    vec++; if (proc2mem_data !== 64'hDEADBEEF_00000000) begin miscompares++; $display("FAIL word_data got %h want deadbeef00000000", proc2mem_data); end
    vec++; if (proc2mem_size !== 2'd2 || mem_req !== 1'b1) begin miscompares++; $display("FAIL word_size_req got %0d/%0b want 2/1", proc2mem_size, mem_req); end
    vec++; if (storecomplete !== 1'b0) begin miscompares++; $display("FAIL word_sc_early got %0b want 0", storecomplete); end
    @(negedge clock);
    vec++; if (storecomplete !== 1'b1 || st_misalign !== 1'b0) begin miscompares++; $display("FAIL word_sc got %0b/%0b want 1/0", storecomplete, st_misalign); end
    st_req = 1'b0;
    @(negedge clock);
    vec++; if (storecomplete !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL word_sc_once got %0b/%0b want 0/0", storecomplete, busy); end
  endtask

  task automatic test_byte_half;
    present(32'h2003, 32'h123456AB, 3'd0);
    @(negedge clock);
    vec++; if (proc2mem_data !== 64'h00000000_AB000000) begin miscompares++; $display("FAIL byte_data got %h want 00000000ab000000", proc2mem_data); end
    vec++; if (proc2mem_size !== 2'd0 || proc2mem_addr !== 32'h2000) begin miscompares++; $display("FAIL byte_size_addr got %0d/%h want 0/00002000", proc2mem_size, proc2mem_addr); end
    @(negedge clock);
    vec++; if (storecomplete !== 1'b1) begin miscompares++; $display("FAIL byte_sc got %0b want 1", storecomplete); end
    present(32'h2006, 32'h0000CAFE, 3'd1);
    @(negedge clock);
    @(negedge clock);
    vec++; if (proc2mem_data !== 64'hCAFE0000_00000000) begin miscompares++; $display("FAIL half_data got %h want cafe000000000000", proc2mem_data); end
    vec++; if (proc2mem_size !== 2'd1 || proc2mem_command !== CMD_STORE) begin miscompares++; $display("FAIL half_size_cmd got %0d/%0d want 1/2", proc2mem_size, proc2mem_command); end
    @(negedge clock);
    vec++; if (storecomplete !== 1'b1) begin miscompares++; $display("FAIL half_sc got %0b want 1", storecomplete); end
    st_req = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_retry;
    mem_grant = 1'b0; mem2proc_response = 4'd0;
    present(32'h4000, 32'h11223344, 3'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      vec++; if (proc2mem_command !== CMD_NONE || mem_req !== 1'b1) begin miscompares++; $display("FAIL retry_nogrant%0d got %0d/%0b want 0/1", i, proc2mem_command, mem_req); end
    end
    mem_grant = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      vec++; if (proc2mem_command !== CMD_STORE || storecomplete !== 1'b0) begin miscompares++; $display("FAIL retry_refused%0d got %0d/%0b want 2/0", i, proc2mem_command, storecomplete); end
    end
    mem2proc_response = 4'd2;
    @(negedge clock);
    vec++; if (storecomplete !== 1'b1) begin miscompares++; $display("FAIL retry_sc got %0b want 1", storecomplete); end
    vec++; if (st_timeout !== 1'b0) begin miscompares++; $display("FAIL retry_timeout got %0b want 0", st_timeout); end
    st_req = 1'b0; mem2proc_response = 4'd1;
    @(negedge clock);
    vec++; if (storecomplete !== 1'b0) begin miscompares++; $display("FAIL retry_sc_once got %0b want 0", storecomplete); end
  endtask

  task automatic test_misalign;
    present(32'h3001, 32'h00005555, 3'd1);
    @(negedge clock);
    vec++; if (storecomplete !== 1'b1 || st_misalign !== 1'b1) begin miscompares++; $display("FAIL mis_pulse got %0b/%0b want 1/1", storecomplete, st_misalign); end
    vec++; if (proc2mem_command !== CMD_NONE || mem_req !== 1'b0) begin miscompares++; $display("FAIL mis_nobus got %0d/%0b want 0/0", proc2mem_command, mem_req); end
    present(32'h3006, 32'h01020304, 3'd2);
    @(negedge clock);
    vec++; if (storecomplete !== 1'b0 || st_misalign !== 1'b0) begin miscompares++; $display("FAIL mis_once got %0b/%0b want 0/0", storecomplete, st_misalign); end
    @(negedge clock);
    vec++; if (st_misalign !== 1'b1 || proc2mem_command !== CMD_NONE) begin miscompares++; $display("FAIL mis_word got %0b/%0d want 1/0", st_misalign, proc2mem_command); end
    st_req = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_timeout;
    mem_grant = 1'b1; mem2proc_response = 4'd0;
    present(32'h5000, 32'hA5A5A5A5, 3'd2);
    @(negedge clock);
    vec++; if (st_timeout !== 1'b0) begin miscompares++; $display("FAIL tmo_start got %0b want 0", st_timeout); end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      vec++; if (st_timeout !== (k >= 4)) begin miscompares++; $display("FAIL tmo_refusal%0d got %0b want %0b", k, st_timeout, (k >= 4)); end
    end
    vec++; if (storecomplete !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL tmo_still_issue got %0b/%0b want 0/1", storecomplete, busy); end
    mem2proc_response = 4'd1;
    @(negedge clock);
    vec++; if (storecomplete !== 1'b1 || st_timeout !== 1'b1) begin miscompares++; $display("FAIL tmo_sc got %0b/%0b want 1/1", storecomplete, st_timeout); end
    st_req = 1'b0;
    @(negedge clock);
    vec++; if (st_timeout !== 1'b1) begin miscompares++; $display("FAIL tmo_sticky got %0b want 1", st_timeout); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] exp_addr [2];
    logic [63:0] exp_data [2];
    int issue_n, done_n, cyc_a, cyc_b;
    exp_addr[0] = 32'h7000; exp_data[0] = 64'h00000000_01020304;
    exp_addr[1] = 32'h7008; exp_data[1] = 64'h00000000_000000EE;
    mem_grant = 1'b0; mem2proc_response = 4'd0;
    present(32'h6000, 32'h99999999, 3'd2);
    @(negedge clock);
    vec++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rst_pre_busy got %0b want 1", busy); end
    reset = 1'b1;
    @(negedge clock);
    vec++; if (busy !== 1'b0 || proc2mem_command !== CMD_NONE || storecomplete !== 1'b0) begin miscompares++; $display("FAIL rst_abort got %0b/%0d/%0b want 0/0/0", busy, proc2mem_command, storecomplete); end
    vec++; if (st_timeout !== 1'b0) begin miscompares++; $display("FAIL rst_timeout got %0b want 0", st_timeout); end
    reset = 1'b0; st_req = 1'b0;
    @(negedge clock);
    vec++; if (storecomplete !== 1'b0) begin miscompares++; $display("FAIL rst_no_sc got %0b want 0", storecomplete); end
    mem_grant = 1'b1; mem2proc_response = 4'd3;
    issue_n = 0; done_n = 0; cyc_a = -1; cyc_b = -1;
    present(32'h7000, 32'h01020304, 3'd2);
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (proc2mem_command === CMD_STORE) begin
        if (issue_n < 2) begin
          vec++; if (proc2mem_addr !== exp_addr[issue_n] || proc2mem_data !== exp_data[issue_n]) begin miscompares++; $display("FAIL queue_issue%0d got %h/%h want %h/%h", issue_n, proc2mem_addr, proc2mem_data, exp_addr[issue_n], exp_data[issue_n]); end
        end
        issue_n++;
      end
      if (storecomplete === 1'b1) begin
        if (done_n == 0) begin
          cyc_a = c; present(32'h7008, 32'h000000EE, 3'd0);
        end else begin
          cyc_b = c; st_req = 1'b0;
        end
        done_n++;
      end
    end
    vec++; if (issue_n != 2 || done_n != 2) begin miscompares++; $display("FAIL queue_counts got %0d/%0d want 2/2", issue_n, done_n); end
    vec++; if (cyc_b - cyc_a != 3) begin miscompares++; $display("FAIL queue_spacing got %0d want 3", cyc_b - cyc_a); end
  endtask

  initial begin
    test_reset;
    test_word;
    test_byte_half;
    test_retry;
    test_misalign;
    test_timeout;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscompares);
    $finish;
  end

endmodule

// File: doc/sq_store_writer.md
Name: sq_store_writer

Overview:
- Memory-side responder for the store queue's retire-write interface.
- Accepts the head store presented by the store queue (address, data, memsize) and issues it as a BUS_STORE on the shared processor-memory port when the port arbiter grants access.
- Retries while memory refuses the command, then returns a one-cycle storecomplete pulse so the store queue can advance its head.
- Sits between the store queue and the memory-port arbiter, alongside the D-cache miss path.

Parameters:
- XLEN, 32, address and store data width
- MEM_DW, 64, memory data bus width in bits; the address lane is addr[2:0]
- RETRY_MAX, 255, maximum refused-issue cycles before the timeout error is raised

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- st_req  in  1  store queue presents a retiring store (storeing or retireen); held until storecomplete
- st_addr  in  XLEN  store byte address
- st_data  in  XLEN  store data, right-justified
- st_memsize  in  3  [1:0] is BYTE=0, HALF=1, WORD=2; bit 2 (unsigned) is ignored for stores
- mem_grant  in  1  arbiter grants the memory port to this block this cycle
- mem2proc_response  in  4  nonzero means the command was accepted (transaction tag)
- storecomplete  out  1  one-cycle pulse: store accepted by memory, or dropped as misaligned
- mem_req  out  1  port request to the arbiter
- proc2mem_command  out  2  BUS_NONE=0, BUS_STORE=2
- proc2mem_addr  out  XLEN  store address with bits [2:0] cleared
- proc2mem_data  out  MEM_DW  data shifted into its byte lane
- proc2mem_size  out  2  copy of st_memsize[1:0]
- st_misalign  out  1  one-cycle pulse with storecomplete when the store was misaligned
- st_timeout  out  1  sticky error; cleared only by reset
- busy  out  1  FSM is not in IDLE

Behaviour:
- Clock and reset: one clock, clock. reset is synchronous and active-high.
- Reset values: FSM=IDLE, latched registers=0, all outputs=0, proc2mem_command=BUS_NONE, retry counter=0, st_timeout=0.
- Reset mid-operation aborts the transaction immediately, with no storecomplete pulse.
- Rollback is not an input. A retired store is architectural, so any in-flight store always finishes.

FSM states: IDLE, ISSUE, DONE.

IDLE:
- If st_req, latch addr, data and size into registers.
- If the store is misaligned (HALF with addr[0]!=0, or WORD with addr[1:0]!=0), go to DONE with st_misalign pending. No bus command is issued.
- Otherwise go to ISSUE.

ISSUE:
- mem_req=1.
- When mem_grant=1, drive from the latched registers:
  - proc2mem_command=BUS_STORE
  - proc2mem_addr={addr[XLEN-1:3],3'b0}
  - proc2mem_data = zero-extended data shifted left by addr[2:0]*8; BYTE and HALF are masked to 8 and 16 bits first
  - proc2mem_size = latched size
- When mem_grant=0, proc2mem_command=BUS_NONE.
- Accepted cycle: mem_grant=1 and mem2proc_response!=0. Go to DONE.
- Refused cycle: mem_grant=1 and mem2proc_response==0. Increment the retry counter, which saturates. When it reaches RETRY_MAX, set st_timeout and keep retrying.
- A cycle without grant does not count as a retry.

DONE:
- storecomplete=1 for exactly one cycle. st_misalign=1 in the same cycle if the store was misaligned.
- Clear the retry counter and go to IDLE.

Timing and handshake:
- Best case: st_req rises in cycle 0 -> issue in cycle 1 -> storecomplete in cycle 2.
- Back-to-back stores complete every 3 cycles minimum.
- storecomplete is registered (state-decoded), never combinational from the memory inputs.
- The store queue drops or re-presents st_req at the edge ending DONE. IDLE therefore always samples the next head entry, and a stale st_req cannot be double-issued.
- st_req changing while in ISSUE is ignored, because the latched copy is used.
- The address wraps only as natural XLEN arithmetic; the lane shift uses addr[2:0] only.

Decomposition:
- Shared sys_defs package:
  - BUS_COMMAND enum (BUS_NONE, BUS_LOAD, BUS_STORE)
  - MEM_SIZE enum (BYTE, HALF, WORD, DOUBLE)
  - XLEN
  - store-writer FSM state enum
- One combinational sub-module, store_lane_align, computes the misalign flag and the lane-shifted MEM_DW data from size, addr[2:0] and data.

Test Plan:
1. WORD store, addr=0x1004, data=0xDEADBEEF, grant tied 1, response=1 on first issue -> cycle 1: command=BUS_STORE, addr=0x1000, data=0xDEADBEEF_00000000; cycle 2: storecomplete pulse, one cycle only.
2. BYTE store, addr=0x2003, data=0x1234_56AB -> data=0x00000000_AB000000, size=0; then HALF at 0x2006, data=0xCAFE -> data=0xCAFE0000_00000000.
3. grant=0 for 5 cycles then 1, response=0 for 3 granted cycles then 2 -> command=BUS_NONE while ungranted; storecomplete 1 cycle after acceptance; st_timeout stays 0.
4. HALF store at 0x3001 -> no BUS_STORE issued; storecomplete and st_misalign pulse together 1 cycle after st_req.
5. RETRY_MAX=4, response held 0 with grant=1 -> st_timeout rises after the 4th refusal and stays 1; response=1 later -> storecomplete, st_timeout still 1 until reset.
6. Assert reset during ISSUE -> next cycle busy=0, command=BUS_NONE, no storecomplete; two queued stores afterwards complete in order, each with exactly one storecomplete pulse.
